// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly datapath: total modmul latency
// helper and the tag carried alongside each in-flight operation.
package ntt_pkg;

  // Tag id width is fixed so the struct can live in the package; NREQ <= 256.
  localparam int unsigned TAG_ID_W = 8;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int unsigned lat_tot(input int unsigned intmul_lat,
                                          input int unsigned modred_lat);
    return 32'd1 + intmul_lat + modred_lat;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping),
// and advances ptr past the winner whenever a grant is made.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_vld
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] r_ptr;

  // Scan from the highest offset down so the lowest offset from ptr wins last.
  always_comb begin
    int v_idx;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    v_idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= int'(NREQ)) begin
        v_idx = v_idx - int'(NREQ);
      end else begin
        v_idx = v_idx;
      end
      if (en && req[v_idx[IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = v_idx[IDX_W-1:0];
      end else begin
        grant_vld = grant_vld;
        grant_idx = grant_idx;
      end
    end
    grant[grant_idx] = grant_vld;
  end

  // Pointer moves one past the winner; explicit wrap keeps it in range for any NREQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (grant_vld) begin
      r_ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/btf_modmul_sched.sv
// Shares one fixed-latency butterfly modmul among NREQ requesters: round-robin
// issue, a latency-matched tag pipe for result routing, per-requester op limit.
module btf_modmul_sched
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ       = 32,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned INTMUL_LAT = 1,
  parameter int unsigned MODRED_LAT = 4,
  parameter int unsigned MAX_OUT    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*LOGQ-1:0] req_b,
  input  logic [NREQ*LOGQ-1:0] req_w,
  output logic [LOGQ-1:0]      mm_b,
  output logic [LOGQ-1:0]      mm_w,
  input  logic [LOGQ-1:0]      mm_o,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [LOGQ-1:0]      rsp_data,
  output logic                 busy
);

  localparam int unsigned LAT_TOT = lat_tot(INTMUL_LAT, MODRED_LAT);
  localparam int unsigned IDX_W   = $clog2(NREQ);
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_grant_vld;
  logic [LOGQ-1:0]  r_mm_b;
  logic [LOGQ-1:0]  r_mm_w;
  tag_t             r_tag [LAT_TOT];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (w_elig),
    .en        (~rst),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .grant_vld (w_grant_vld)
  );

  assign req_ready = w_grant;
  assign mm_b      = r_mm_b;
  assign mm_w      = r_mm_w;
  assign rsp_data  = mm_o;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_req
      logic [CNT_W-1:0] r_out;

      assign w_elig[g]    = req_valid[g] & (r_out < CNT_W'(MAX_OUT));
      assign rsp_valid[g] = r_tag[LAT_TOT-1].vld & (r_tag[LAT_TOT-1].id == TAG_ID_W'(g));

      // Issue and response in the same cycle cancel out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out <= '0;
        end else if (w_grant[g] & ~rsp_valid[g]) begin
          r_out <= r_out + CNT_W'(1);
        end else if (~w_grant[g] & rsp_valid[g]) begin
          r_out <= r_out - CNT_W'(1);
        end else begin
          r_out <= r_out;
        end
      end
    end
  endgenerate

  // Operand register feeding the modmul; holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mm_b <= '0;
      r_mm_w <= '0;
    end else if (w_grant_vld) begin
      r_mm_b <= req_b[w_grant_idx*LOGQ +: LOGQ];
      r_mm_w <= req_w[w_grant_idx*LOGQ +: LOGQ];
    end else begin
      r_mm_b <= r_mm_b;
      r_mm_w <= r_mm_w;
    end
  end

  // Tag pipe: stage 0 aligns with the operand register, last stage with mm_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT_TOT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0].vld <= w_grant_vld;
      r_tag[0].id  <= TAG_ID_W'(w_grant_idx);
      for (int i = 1; i < LAT_TOT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT_TOT; i++) begin
      busy = busy | r_tag[i].vld;
    end
  end

endmodule
